control_sequencer: RTL and testbench

//  Hardwired Mini-SRC control unit sitting directly upstream of the datapath.

---
 rtl/minisrc_ctl_pkg.sv | 129 ++++++++++++
 rtl/mem_wait_counter.sv | 28 ++
 rtl/control_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_ctl_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit: opcodes, FSM states,
// instruction classes and bit positions inside the drive/latch/gsel vectors.
package minisrc_ctl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BRX  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int DRIVE_W = 8;
    localparam int LATCH_W = 12;
    localparam int GSEL_W  = 5;

    localparam int D_PCOUT      = 0;
    localparam int D_MDROUT     = 1;
    localparam int D_ZHIGHOUT   = 2;
    localparam int D_ZLOWOUT    = 3;
    localparam int D_HIOUT      = 4;
    localparam int D_LOOUT      = 5;
    localparam int D_COUT       = 6;
    localparam int D_INPORTOUT  = 7;

    localparam int L_PCIN       = 0;
    localparam int L_IRIN       = 1;
    localparam int L_MARIN      = 2;
    localparam int L_MDRIN      = 3;
    localparam int L_YIN        = 4;
    localparam int L_ZHIGHIN    = 5;
    localparam int L_ZLOWIN     = 6;
    localparam int L_HIIN       = 7;
    localparam int L_LOIN       = 8;
    localparam int L_CONIN      = 9;
    localparam int L_OUTPORTIN  = 10;
    localparam int L_RIN        = 11;

    localparam int G_GRA   = 0;
    localparam int G_GRB   = 1;
    localparam int G_GRC   = 2;
    localparam int G_ROUT  = 3;
    localparam int G_BAOUT = 4;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
        ST_HALT,
        ST_PAUSE
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_MULDIV, CL_UNARY, CL_BRX,
        CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
    } op_class_t;

    function automatic op_class_t classify(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: return CL_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:                return CL_IMM;
            OP_LD:                                   return CL_LD;
            OP_LDI:                                  return CL_LDI;
            OP_ST:                                   return CL_ST;
            OP_MUL, OP_DIV:                          return CL_MULDIV;
            OP_NEG, OP_NOT:                          return CL_UNARY;
            OP_BRX:                                  return CL_BRX;
            OP_JR:                                   return CL_JR;
            OP_JAL:                                  return CL_JAL;
            OP_IN:                                   return CL_IN;
            OP_OUT:                                  return CL_OUT;
            OP_MFHI:                                 return CL_MFHI;
            OP_MFLO:                                 return CL_MFLO;
            OP_HALT:                                 return CL_HALT;
            default:                                 return CL_NOP;
        endcase
    endfunction

    // Final execute step of each class; nop/undefined end right after fetch.
    function automatic state_t last_state(input op_class_t cls);
        case (cls)
            CL_ALU, CL_IMM, CL_LDI:              return ST_T5;
            CL_LD, CL_ST:                        return ST_T7;
            CL_MULDIV, CL_BRX:                   return ST_T6;
            CL_UNARY, CL_JAL:                    return ST_T4;
            CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO: return ST_T3;
            default:                             return ST_T2;
        endcase
    endfunction

    function automatic logic is_mem_state(input state_t s, input op_class_t cls);
        return (s == ST_T1) || (s == ST_T6 && cls == CL_LD) || (s == ST_T7 && cls == CL_ST);
    endfunction

    function automatic state_t next_step(input state_t s);
        case (s)
            ST_T0:   return ST_T1;
            ST_T1:   return ST_T2;
            ST_T2:   return ST_T3;
            ST_T3:   return ST_T4;
            ST_T4:   return ST_T5;
            ST_T5:   return ST_T6;
            ST_T6:   return ST_T7;
            default: return ST_T0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory wait-state counter: loaded on entry to a memory step, counts down to zero
// while the step holds its strobes.
module mem_wait_counter #(
    parameter int WAIT_W = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_value,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - WAIT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini-SRC control sequencer: fetch T0-T2, per-class execute T3-T7,
// memory wait states and HALT. Define CTL_STEP_EN to add the step port and PAUSE state.
module control_sequencer
    import minisrc_ctl_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [31:0]        ir,
    input  logic               con,
`ifdef CTL_STEP_EN
    input  logic               step,
`endif
    output logic [DRIVE_W-1:0] drive,
    output logic [LATCH_W-1:0] latch,
    output logic [GSEL_W-1:0]  gsel,
    output logic               IncPC,
    output logic               Read,
    output logic               Write,
    output logic [4:0]         alu_op,
    output logic               run
);

    if (MEM_WAIT < 0 || MEM_WAIT >= (1 << WAIT_W)) begin : g_wait_range
        $error("MEM_WAIT must fit in WAIT_W bits");
    end

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT);

`ifdef CTL_STEP_EN
    localparam state_t DONE_STATE = ST_PAUSE;
`else
    localparam state_t DONE_STATE = ST_T0;
`endif

    state_t    state;
    state_t    state_nxt;
    logic [4:0] opcode;
    op_class_t cls;
    logic      cnt_load;
    logic      cnt_dec;
    logic      cnt_zero;
    logic      unused_ir_bits;

    assign opcode         = ir[31:27];
    assign cls            = classify(opcode);
    assign unused_ir_bits = ^ir[26:0];

    // A memory step reloads the counter only when it is being entered.
    assign cnt_load = is_mem_state(state_nxt, cls) && (state_nxt != state);
    assign cnt_dec  = is_mem_state(state, cls) && !cnt_zero;

    mem_wait_counter #(
        .WAIT_W(WAIT_W)
    ) u_wait (
        .clock      (clock),
        .clear      (clear),
        .load       (cnt_load),
        .load_value (WAIT_INIT),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET: state_nxt = ST_T0;
            ST_HALT:  state_nxt = ST_HALT;
`ifdef CTL_STEP_EN
            ST_PAUSE: state_nxt = step ? ST_T0 : ST_PAUSE;
`else
            ST_PAUSE: state_nxt = ST_T0;
`endif
            default: begin
                if (is_mem_state(state, cls) && !cnt_zero) begin
                    state_nxt = state;
                end else if (state == ST_T2 && cls == CL_HALT) begin
                    state_nxt = ST_HALT;
                end else if (state == last_state(cls)) begin
                    state_nxt = DONE_STATE;
                end else begin
                    state_nxt = next_step(state);
                end
            end
        endcase
    end

    always_comb begin
        drive  = '0;
        latch  = '0;
        gsel   = '0;
        IncPC  = 1'b0;
        Read   = 1'b0;
        Write  = 1'b0;
        alu_op = '0;
        run    = 1'b0;
        if (state != ST_RESET && state != ST_HALT && state != ST_PAUSE) begin
            run    = 1'b1;
            alu_op = opcode;
        end
        case (state)
            ST_T0: begin
                drive[D_PCOUT]  = 1'b1;
                latch[L_MARIN]  = 1'b1;
                latch[L_ZLOWIN] = 1'b1;
                IncPC           = 1'b1;
            end
            ST_T1: begin
                drive[D_ZLOWOUT] = 1'b1;
                latch[L_PCIN]    = 1'b1;
                latch[L_MDRIN]   = 1'b1;
                Read             = 1'b1;
            end
            ST_T2: begin
                drive[D_MDROUT] = 1'b1;
                latch[L_IRIN]   = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CL_ALU, CL_IMM: begin
                        gsel[G_GRB] = 1'b1; gsel[G_ROUT] = 1'b1; latch[L_YIN] = 1'b1;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        gsel[G_GRB] = 1'b1; gsel[G_BAOUT] = 1'b1; latch[L_YIN] = 1'b1;
                    end
                    CL_MULDIV: begin
                        gsel[G_GRA] = 1'b1; gsel[G_ROUT] = 1'b1; latch[L_YIN] = 1'b1;
                    end
                    CL_UNARY: begin
                        gsel[G_GRB] = 1'b1; gsel[G_ROUT] = 1'b1; latch[L_ZLOWIN] = 1'b1;
                    end
                    CL_BRX: begin
                        gsel[G_GRA] = 1'b1; gsel[G_ROUT] = 1'b1; latch[L_CONIN] = 1'b1;
                    end
                    CL_JR: begin
                        gsel[G_GRA] = 1'b1; gsel[G_ROUT] = 1'b1; latch[L_PCIN] = 1'b1;
                    end
                    CL_JAL: begin
                        drive[D_PCOUT] = 1'b1; gsel[G_GRB] = 1'b1; latch[L_RIN] = 1'b1;
                    end
                    CL_IN: begin
                        drive[D_INPORTOUT] = 1'b1; gsel[G_GRA] = 1'b1; latch[L_RIN] = 1'b1;
                    end
                    CL_OUT: begin
                        gsel[G_GRA] = 1'b1; gsel[G_ROUT] = 1'b1; latch[L_OUTPORTIN] = 1'b1;
                    end
                    CL_MFHI: begin
                        drive[D_HIOUT] = 1'b1; gsel[G_GRA] = 1'b1; latch[L_RIN] = 1'b1;
                    end
                    CL_MFLO: begin
                        drive[D_LOOUT] = 1'b1; gsel[G_GRA] = 1'b1; latch[L_RIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CL_ALU: begin
                        gsel[G_GRC] = 1'b1; gsel[G_ROUT] = 1'b1; latch[L_ZLOWIN] = 1'b1;
                    end
                    CL_IMM: begin
                        drive[D_COUT] = 1'b1; latch[L_ZLOWIN] = 1'b1;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        drive[D_COUT] = 1'b1; latch[L_ZLOWIN] = 1'b1; alu_op = OP_ADD;
                    end
                    CL_MULDIV: begin
                        gsel[G_GRB] = 1'b1; gsel[G_ROUT] = 1'b1;
                        latch[L_ZHIGHIN] = 1'b1; latch[L_ZLOWIN] = 1'b1;
                    end
                    CL_UNARY: begin
                        drive[D_ZLOWOUT] = 1'b1; gsel[G_GRA] = 1'b1; latch[L_RIN] = 1'b1;
                    end
                    CL_BRX: begin
                        drive[D_PCOUT] = 1'b1; latch[L_YIN] = 1'b1;
                    end
                    CL_JAL: begin
                        gsel[G_GRA] = 1'b1; gsel[G_ROUT] = 1'b1; latch[L_PCIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CL_ALU, CL_IMM, CL_LDI: begin
                        drive[D_ZLOWOUT] = 1'b1; gsel[G_GRA] = 1'b1; latch[L_RIN] = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        drive[D_ZLOWOUT] = 1'b1; latch[L_MARIN] = 1'b1;
                    end
                    CL_MULDIV: begin
                        drive[D_ZLOWOUT] = 1'b1; latch[L_LOIN] = 1'b1;
                    end
                    CL_BRX: begin
                        drive[D_COUT] = 1'b1; latch[L_ZLOWIN] = 1'b1; alu_op = OP_ADD;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CL_LD: begin
                        Read = 1'b1; latch[L_MDRIN] = 1'b1;
                    end
                    CL_ST: begin
                        gsel[G_GRA] = 1'b1; gsel[G_ROUT] = 1'b1; latch[L_MDRIN] = 1'b1;
                    end
                    CL_MULDIV: begin
                        drive[D_ZHIGHOUT] = 1'b1; latch[L_HIIN] = 1'b1;
                    end
                    // Branch target is committed only when the CON flip-flop says taken.
                    CL_BRX: begin
                        drive[D_ZLOWOUT] = con; latch[L_PCIN] = con;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (cls)
                    CL_LD: begin
                        drive[D_MDROUT] = 1'b1; gsel[G_GRA] = 1'b1; latch[L_RIN] = 1'b1;
                    end
                    CL_ST: Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench: two sequencers (MEM_WAIT 0 and 2) compared every
// cycle against an instruction-level expansion of the control-step tables.
module tb_control_sequencer;

    localparam int MW0 = 0;
    localparam int MW1 = 2;

    localparam logic [4:0] LD_OP = 5'd0, LDI_OP = 5'd1, ST_OP = 5'd2, ADD_OP = 5'd3;
    localparam logic [4:0] BRX_OP = 5'd19, NOP_OP = 5'd26, HALT_OP = 5'd27;

    localparam logic [7:0] PCO = 8'h01, MDRO = 8'h02, ZHO = 8'h04, ZLO = 8'h08;
    localparam logic [7:0] HIO = 8'h10, LOO = 8'h20, CO = 8'h40, INPO = 8'h80;
    localparam logic [11:0] PCI = 12'h001, IRI = 12'h002, MARI = 12'h004, MDRI = 12'h008;
    localparam logic [11:0] YI = 12'h010, ZHI = 12'h020, ZLI = 12'h040, HII = 12'h080;
    localparam logic [11:0] LOI = 12'h100, CONI = 12'h200, OUTI = 12'h400, RI = 12'h800;
    localparam logic [4:0] GRA = 5'h01, GRB = 5'h02, GRC = 5'h04, ROUT = 5'h08, BAO = 5'h10;

    typedef struct packed {
        logic [7:0]  d;
        logic [11:0] l;
        logic [4:0]  g;
        logic        inc;
        logic        rd;
        logic        wr;
        logic [4:0]  alu;
        logic        run;
    } cyc_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]        clear_s;
    logic [1:0][31:0]  ir_s;
    logic [1:0]        con_s;
`ifdef CTL_STEP_EN
    logic [1:0]        step_s;
    logic              stp_q[$];
    int                pause_fix = -1;
`endif
    wire [1:0][7:0]    drive_s;
    wire [1:0][11:0]   latch_s;
    wire [1:0][4:0]    gsel_s;
    wire [1:0][4:0]    alu_s;
    wire [1:0]         incpc_s, read_s, write_s, run_s;

    int checks = 0;
    int errors = 0;
    cyc_t exp_q[$];

    control_sequencer #(.MEM_WAIT(MW0), .WAIT_W(4)) dut0 (
        .clock(clock), .clear(clear_s[0]), .ir(ir_s[0]), .con(con_s[0]),
`ifdef CTL_STEP_EN
        .step(step_s[0]),
`endif
        .drive(drive_s[0]), .latch(latch_s[0]), .gsel(gsel_s[0]), .IncPC(incpc_s[0]),
        .Read(read_s[0]), .Write(write_s[0]), .alu_op(alu_s[0]), .run(run_s[0])
    );

    control_sequencer #(.MEM_WAIT(MW1), .WAIT_W(4)) dut1 (
        .clock(clock), .clear(clear_s[1]), .ir(ir_s[1]), .con(con_s[1]),
`ifdef CTL_STEP_EN
        .step(step_s[1]),
`endif
        .drive(drive_s[1]), .latch(latch_s[1]), .gsel(gsel_s[1]), .IncPC(incpc_s[1]),
        .Read(read_s[1]), .Write(write_s[1]), .alu_op(alu_s[1]), .run(run_s[1])
    );

    task automatic put(input logic [7:0] d, input logic [11:0] l, input logic [4:0] g,
                       input logic [4:0] alu, input int reps, input logic [2:0] irw);
        cyc_t e;
        e.d = d; e.l = l; e.g = g; e.alu = alu; e.run = 1'b1;
        e.inc = irw[2]; e.rd = irw[1]; e.wr = irw[0];
        repeat (reps) exp_q.push_back(e);
    endtask

    // Expected per-cycle outputs of one instruction from fetch to its last step.
    task automatic expand(input logic [4:0] op, input logic c, input int mw);
        exp_q.delete();
        put(PCO, MARI | ZLI, '0, op, 1, 3'b100);
        put(ZLO, PCI | MDRI, '0, op, mw + 1, 3'b010);
        put(MDRO, IRI, '0, op, 1, 3'b000);
        case (op) inside
            [5'd3:5'd14]: begin
                put('0, YI, GRB | ROUT, op, 1, 3'b000);
                if (op <= 5'd11) put('0, ZLI, GRC | ROUT, op, 1, 3'b000);
                else             put(CO, ZLI, '0, op, 1, 3'b000);
                put(ZLO, RI, GRA, op, 1, 3'b000);
            end
            [5'd0:5'd2]: begin
                put('0, YI, GRB | BAO, op, 1, 3'b000);
                put(CO, ZLI, '0, ADD_OP, 1, 3'b000);
                if (op == LDI_OP) begin
                    put(ZLO, RI, GRA, op, 1, 3'b000);
                end else begin
                    put(ZLO, MARI, '0, op, 1, 3'b000);
                    if (op == LD_OP) begin
                        put('0, MDRI, '0, op, mw + 1, 3'b010);
                        put(MDRO, RI, GRA, op, 1, 3'b000);
                    end else begin
                        put('0, MDRI, GRA | ROUT, op, 1, 3'b000);
                        put('0, '0, '0, op, mw + 1, 3'b001);
                    end
                end
            end
            5'd15, 5'd16: begin
                put('0, YI, GRA | ROUT, op, 1, 3'b000);
                put('0, ZHI | ZLI, GRB | ROUT, op, 1, 3'b000);
                put(ZLO, LOI, '0, op, 1, 3'b000);
                put(ZHO, HII, '0, op, 1, 3'b000);
            end
            5'd17, 5'd18: begin
                put('0, ZLI, GRB | ROUT, op, 1, 3'b000);
                put(ZLO, RI, GRA, op, 1, 3'b000);
            end
            5'd19: begin
                put('0, CONI, GRA | ROUT, op, 1, 3'b000);
                put(PCO, YI, '0, op, 1, 3'b000);
                put(CO, ZLI, '0, ADD_OP, 1, 3'b000);
                put(c ? ZLO : 8'h00, c ? PCI : 12'h000, '0, op, 1, 3'b000);
            end
            5'd20: put('0, PCI, GRA | ROUT, op, 1, 3'b000);
            5'd21: begin
                put(PCO, RI, GRB, op, 1, 3'b000);
                put('0, PCI, GRA | ROUT, op, 1, 3'b000);
            end
            5'd22: put(INPO, RI, GRA, op, 1, 3'b000);
            5'd23: put('0, OUTI, GRA | ROUT, op, 1, 3'b000);
            5'd24: put(HIO, RI, GRA, op, 1, 3'b000);
            5'd25: put(LOO, RI, GRA, op, 1, 3'b000);
            default: ;
        endcase
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_cyc(input int k, input cyc_t e, input string name);
        cyc_t a;
        a.d = drive_s[k]; a.l = latch_s[k]; a.g = gsel_s[k]; a.inc = incpc_s[k];
        a.rd = read_s[k]; a.wr = write_s[k]; a.alu = alu_s[k]; a.run = run_s[k];
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d: got %h required %h (t=%0t)", name, k, a, e, $time);
        end
        checks++;
        if ($countones(a.d) > 1 || (a.rd && a.wr)) begin
            errors++;
            $display("FAIL %s_bus dut%0d: drive %h rd %b wr %b required one-hot, no rd+wr",
                     name, k, a.d, a.rd, a.wr);
        end
    endtask

    task automatic do_reset(input int k);
        clear_s[k] = 1'b1;
        #1 check_cyc(k, '0, "clear");
        @(negedge clock);
        check_cyc(k, '0, "reset_hold");
        clear_s[k] = 1'b0;
        @(negedge clock);
    endtask

    // Entered at the negedge of the instruction's T0; leaves at the next T0 (or abort point).
    task automatic run_instr(input int k, input logic [4:0] op, input logic c, input int abort_at);
        int mw;
        mw = (k == 0) ? MW0 : MW1;
        expand(op, c, mw);
`ifdef CTL_STEP_EN
        stp_q.delete();
        foreach (exp_q[i]) stp_q.push_back(1'($urandom_range(0, 1)));
        if (op != HALT_OP) begin
            int p;
            p = (pause_fix < 0) ? $urandom_range(0, 3) : pause_fix;
            for (int i = 0; i <= p; i++) begin
                exp_q.push_back('0);
                stp_q.push_back(i == p);
            end
        end
`endif
        ir_s[k] = {op, 27'($urandom)};
        con_s[k] = c;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == abort_at) return;
`ifdef CTL_STEP_EN
            step_s[k] = stp_q[i];
`endif
            #1 check_cyc(k, exp_q[i], $sformatf("op%0d_cyc%0d", op, i));
            @(negedge clock);
        end
    endtask

    initial begin
        clear_s = '0;
        ir_s = '0;
        con_s = '0;
`ifdef CTL_STEP_EN
        step_s = '0;
`endif
        #1 clear_s = '1;

        expand(ADD_OP, 1'b0, 0);
        check_int("model_add_len", exp_q.size(), 6);
        check_int("model_add_t0", {exp_q[0].d, exp_q[0].l, exp_q[0].inc}, {8'h01, 12'h044, 1'b1});
        check_int("model_add_t5", {exp_q[5].d, exp_q[5].l, exp_q[5].g, exp_q[5].alu},
                  {8'h08, 12'h800, 5'h01, 5'h03});
        expand(LD_OP, 1'b0, 2);
        check_int("model_ld_len", exp_q.size(), 12);
        check_int("model_ld_t6_last", {exp_q[10].l, exp_q[10].rd}, {12'h008, 1'b1});
        expand(BRX_OP, 1'b0, 0);
        check_int("model_brx0_t6", {exp_q[6].d, exp_q[6].l}, 0);
        check_int("model_brx_t5_alu", exp_q[5].alu, 3);
        expand(BRX_OP, 1'b1, 0);
        check_int("model_brx1_t6", {exp_q[6].d, exp_q[6].l}, {8'h08, 12'h001});

        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            do_reset(k);
            run_instr(k, ADD_OP, 1'b0, -1);
            run_instr(k, LD_OP, 1'b0, -1);
            run_instr(k, ST_OP, 1'b1, -1);
            run_instr(k, BRX_OP, 1'b0, -1);
            run_instr(k, BRX_OP, 1'b1, -1);
`ifdef CTL_STEP_EN
            pause_fix = 20;
            run_instr(k, NOP_OP, 1'b0, -1);
            pause_fix = -1;
`endif
            run_instr(k, ADD_OP, 1'b0, 4 + ((k == 0) ? MW0 : MW1));
            do_reset(k);
            repeat (120) begin
                logic [4:0] op;
                op = 5'($urandom_range(0, 31));
                if (op == HALT_OP) op = NOP_OP;
                run_instr(k, op, 1'($urandom_range(0, 1)), -1);
            end
            run_instr(k, HALT_OP, 1'b0, -1);
            for (int i = 0; i < 100; i++) begin
                ir_s[k] = $urandom;
                con_s[k] = 1'($urandom_range(0, 1));
                #1 check_cyc(k, '0, "halt_hold");
                @(negedge clock);
            end
            do_reset(k);
            run_instr(k, ADD_OP, 1'b0, -1);
            clear_s[k] = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
